// File: rtl/tpu_thread_rcv_pkg.sv
// Shared types for tpu_thread_rcv: commit number (pkg_mpu),
// receiver FSM states and header field layout (pkg_tpu).
package pkg_mpu;
    localparam int COMMIT_NO_W = 4;
    typedef logic [COMMIT_NO_W-1:0] commit_no_t;
endpackage

package pkg_tpu;
    localparam int INSTR_W = 32;
    typedef logic [INSTR_W-1:0] instr_t;

    localparam int HDR_ISSUE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        COMMIT
    } rcv_state_e;

    // The length field sits directly above the issue number.
    function automatic int hdr_len_lsb(input int w_sth);
        return HDR_ISSUE_LSB + w_sth;
    endfunction
endpackage

// File: rtl/tpu_thread_rcv_if.sv
// MPU-side channel of tpu_thread_rcv: word dispatch in,
// busy/commit/drop status out.
interface tpu_thread_rcv_if #(
    parameter int WIDTH_INSTR     = pkg_tpu::INSTR_W,
    parameter int WIDTH_ENTRY_STH = pkg_mpu::COMMIT_NO_W
);
    logic                       I_Req_Instr;
    logic [WIDTH_INSTR-1:0]     I_Instr;
    logic                       O_Busy;
    logic                       O_Req_Commit;
    logic [WIDTH_ENTRY_STH-1:0] O_CommitNo;
    logic [7:0]                 O_Drop_Cnt;

    modport master (
        output I_Req_Instr, I_Instr,
        input  O_Busy, O_Req_Commit, O_CommitNo, O_Drop_Cnt
    );

    modport slave (
        input  I_Req_Instr, I_Instr,
        output O_Busy, O_Req_Commit, O_CommitNo, O_Drop_Cnt
    );
endinterface

// File: rtl/tpu_thread_rcv.sv
// Thread receiver: takes a header + L words from the MPU, fills the
// local imem, starts the core and commits. Option: TPU_RCV_LEN_CHECK_EN.
module tpu_thread_rcv
    import pkg_tpu::*;
#(
    parameter int WIDTH_INSTR     = INSTR_W,
    parameter int WIDTH_ENTRY_STH = pkg_mpu::COMMIT_NO_W,
    parameter int WIDTH_LEN       = 8,
    parameter int IMEM_DEPTH      = 256
) (
    input  logic                          clock,
    input  logic                          reset,
    tpu_thread_rcv_if.slave               mpu,
    output logic                          O_IMem_We,
    output logic [$clog2(IMEM_DEPTH)-1:0] O_IMem_Addr,
    output logic [WIDTH_INSTR-1:0]        O_IMem_Data,
    output logic                          O_Start,
    output logic [WIDTH_LEN-1:0]          O_Length,
    input  logic                          I_Done
`ifdef TPU_RCV_LEN_CHECK_EN
    ,
    output logic                          O_Err
`endif
);
    localparam int ADDR_W  = $clog2(IMEM_DEPTH);
    localparam int LEN_LSB = hdr_len_lsb(WIDTH_ENTRY_STH);

    rcv_state_e                 state_q, state_d;
    logic [WIDTH_ENTRY_STH-1:0] issue_q;
    logic [WIDTH_LEN-1:0]       len_q;
    logic [WIDTH_LEN-1:0]       cnt_q;
    logic                       start_pend_q;
    logic [7:0]                 drop_q;

    logic [WIDTH_ENTRY_STH-1:0] hdr_issue;
    logic [WIDTH_LEN-1:0]       hdr_len;
    logic                       hdr_take;
    logic                       word_take;
    logic                       last_word;
    logic                       busy;

    assign hdr_issue = mpu.I_Instr[HDR_ISSUE_LSB +: WIDTH_ENTRY_STH];
    assign hdr_len   = mpu.I_Instr[LEN_LSB +: WIDTH_LEN];

`ifdef TPU_RCV_LEN_CHECK_EN
    localparam logic [WIDTH_LEN:0] DEPTH_L = IMEM_DEPTH[WIDTH_LEN:0];
    logic hdr_bad;
`endif

    always_comb begin
        state_d   = state_q;
        hdr_take  = 1'b0;
        word_take = 1'b0;
        last_word = 1'b0;
`ifdef TPU_RCV_LEN_CHECK_EN
        hdr_bad   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (mpu.I_Req_Instr) begin
`ifdef TPU_RCV_LEN_CHECK_EN
                    if (hdr_len == '0 ||
                        {1'b0, hdr_len} > DEPTH_L) begin
                        hdr_bad = 1'b1;
                    end else begin
                        hdr_take = 1'b1;
                        state_d  = LOAD;
                    end
`else
                    // An empty thread still owes the MPU a commit.
                    hdr_take = 1'b1;
                    state_d  = (hdr_len == '0) ? COMMIT : LOAD;
`endif
                end
            end
            LOAD: begin
                if (mpu.I_Req_Instr) begin
                    word_take = 1'b1;
                    if (cnt_q == len_q - 1'b1) begin
                        last_word = 1'b1;
                        state_d   = RUN;
                    end
                end
            end
            RUN: begin
                if (I_Done) state_d = COMMIT;
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == COMMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            issue_q      <= '0;
            len_q        <= '0;
            cnt_q        <= '0;
            start_pend_q <= 1'b0;
            drop_q       <= '0;
            O_IMem_We    <= 1'b0;
            O_IMem_Addr  <= '0;
            O_IMem_Data  <= '0;
            O_Start      <= 1'b0;
`ifdef TPU_RCV_LEN_CHECK_EN
            O_Err        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            O_IMem_We    <= word_take;
            // Start trails the last write by one cycle.
            start_pend_q <= last_word;
            O_Start      <= start_pend_q;
`ifdef TPU_RCV_LEN_CHECK_EN
            O_Err        <= hdr_bad;
`endif
            if (hdr_take) begin
                issue_q <= hdr_issue;
                len_q   <= hdr_len;
                cnt_q   <= '0;
            end
            if (word_take) begin
                O_IMem_Addr <= cnt_q[ADDR_W-1:0];
                O_IMem_Data <= mpu.I_Instr;
                cnt_q       <= cnt_q + 1'b1;
            end
            if (mpu.I_Req_Instr && busy && drop_q != 8'hFF) begin
                drop_q <= drop_q + 8'd1;
            end
        end
    end

    assign O_Length         = len_q;
    assign mpu.O_Busy       = busy;
    assign mpu.O_Req_Commit = (state_q == COMMIT);
    assign mpu.O_CommitNo   = issue_q;
    assign mpu.O_Drop_Cnt   = drop_q;
endmodule

// File: tb/tb_tpu_thread_rcv.sv
// Directed bench for tpu_thread_rcv; build with
// +define+TPU_RCV_LEN_CHECK_EN to exercise the length check.
module tb_tpu_thread_rcv;
    import pkg_mpu::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        we;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        start;
    logic [7:0]  length;
    logic        done = 1'b0;
`ifdef TPU_RCV_LEN_CHECK_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cnt = 0;
    int start_cyc = 0;
    int we_cyc = 0;
    int commit_cnt = 0;
    int err_cnt = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];

    tpu_thread_rcv_if #(.WIDTH_INSTR(32), .WIDTH_ENTRY_STH(4)) mpu ();

    tpu_thread_rcv dut (
        .clock       (clock),
        .reset       (reset),
        .mpu         (mpu),
        .O_IMem_We   (we),
        .O_IMem_Addr (addr),
        .O_IMem_Data (data),
        .O_Start     (start),
        .O_Length    (length),
        .I_Done      (done)
`ifdef TPU_RCV_LEN_CHECK_EN
        ,
        .O_Err       (err)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (we) begin
            wa.push_back(addr);
            wd.push_back(data);
            we_cyc = cyc;
        end
        if (start) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (mpu.O_Req_Commit) commit_cnt++;
`ifdef TPU_RCV_LEN_CHECK_EN
        if (err) err_cnt++;
`endif
    end

    function automatic logic [31:0] hdr(input logic [3:0] issue,
                                        input logic [7:0] len);
        return {20'd0, len, issue};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clr();
        wa.delete();
        wd.delete();
        start_cnt  = 0;
        commit_cnt = 0;
        err_cnt    = 0;
    endtask

    task automatic send(input logic [31:0] w);
        mpu.I_Req_Instr = 1'b1;
        mpu.I_Instr     = w;
        tick();
        mpu.I_Req_Instr = 1'b0;
    endtask

    task automatic finish_thread(input string nm,
                                 input commit_no_t no);
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (mpu.O_Req_Commit !== 1'b1 || mpu.O_CommitNo !== no) begin
            errors++;
            $display("FAIL %s_commit: got req=%0b no=%0d want 1/%0d",
                     nm, mpu.O_Req_Commit, mpu.O_CommitNo, no);
        end
        tick();
        checks++;
        if (mpu.O_Req_Commit !== 1'b0 || mpu.O_Busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_post_commit: req=%0b busy=%0b want 0/0",
                     nm, mpu.O_Req_Commit, mpu.O_Busy);
        end
    endtask

    task automatic test_reset();
        mpu.I_Req_Instr = 1'b0;
        mpu.I_Instr     = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++;
        if ({mpu.O_Busy, we, start, mpu.O_Req_Commit} !== 4'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 0000",
                     {mpu.O_Busy, we, start, mpu.O_Req_Commit});
        end
        checks++;
        if (addr !== 8'd0 || data !== 32'd0 || length !== 8'd0 ||
            mpu.O_CommitNo !== 4'd0 || mpu.O_Drop_Cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_regs: a=%0d d=%0h l=%0d n=%0d c=%0d want 0",
                     addr, data, length, mpu.O_CommitNo, mpu.O_Drop_Cnt);
        end
    endtask

    task automatic test_basic();
        clr();
        send(hdr(4'd5, 8'd3));
        mpu.I_Req_Instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mpu.I_Instr = 32'h100 + i;
            tick();
        end
        mpu.I_Req_Instr = 1'b0;
        checks++;
        if (we !== 1'b1 || addr !== 8'd2 || start !== 1'b0) begin
            errors++;
            $display("FAIL basic_last_write: we=%0b a=%0d st=%0b want 1/2/0",
                     we, addr, start);
        end
        tick();
        checks++;
        if (start !== 1'b1 || length !== 8'd3 || mpu.O_Busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_start: st=%0b len=%0d busy=%0b want 1/3/1",
                     start, length, mpu.O_Busy);
        end
        tick();
        checks++;
        if (wa.size() != 3 || start_cnt != 1 ||
            start_cyc != we_cyc + 1) begin
            errors++;
            $display("FAIL basic_counts: wr=%0d st=%0d gap=%0d want 3/1/1",
                     wa.size(), start_cnt, start_cyc - we_cyc);
        end
        for (int i = 0; i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== i[7:0] || wd[i] !== 32'h100 + i) begin
                errors++;
                $display("FAIL basic_wr%0d: a=%0d d=%0h want %0d/%0h",
                         i, wa[i], wd[i], i, 32'h100 + i);
            end
        end
        finish_thread("basic", 4'd5);
    endtask

    task automatic test_gaps();
        clr();
        send(hdr(4'd6, 8'd4));
        for (int i = 0; i < 4; i++) begin
            send(32'hA000 + i);
            tick();
            tick();
        end
        tick();
        tick();
        checks++;
        if (wa.size() != 4 || start_cnt != 1 || length !== 8'd4) begin
            errors++;
            $display("FAIL gaps_counts: wr=%0d st=%0d len=%0d want 4/1/4",
                     wa.size(), start_cnt, length);
        end
        for (int i = 0; i < wa.size(); i++) begin
            checks++;
            if (wa[i] !== i[7:0] || wd[i] !== 32'hA000 + i) begin
                errors++;
                $display("FAIL gaps_wr%0d: a=%0d d=%0h want %0d/%0h",
                         i, wa[i], wd[i], i, 32'hA000 + i);
            end
        end
        finish_thread("gaps", 4'd6);
    endtask

    task automatic test_drop();
        clr();
        send(hdr(4'd7, 8'd1));
        send(32'hBEEF);
        tick();
        tick();
        mpu.I_Req_Instr = 1'b1;
        for (int i = 0; i < 3; i++) begin
            mpu.I_Instr = 32'hD0 + i;
            tick();
        end
        mpu.I_Req_Instr = 1'b0;
        tick();
        checks++;
        if (mpu.O_Drop_Cnt !== 8'd3 || wa.size() != 1 ||
            mpu.O_Busy !== 1'b1) begin
            errors++;
            $display("FAIL drop_3: cnt=%0d wr=%0d busy=%0b want 3/1/1",
                     mpu.O_Drop_Cnt, wa.size(), mpu.O_Busy);
        end
        mpu.I_Req_Instr = 1'b1;
        for (int i = 0; i < 260; i++) tick();
        mpu.I_Req_Instr = 1'b0;
        tick();
        checks++;
        if (mpu.O_Drop_Cnt !== 8'd255 || wa.size() != 1) begin
            errors++;
            $display("FAIL drop_sat: cnt=%0d wr=%0d want 255/1",
                     mpu.O_Drop_Cnt, wa.size());
        end
        finish_thread("drop", 4'd7);
    endtask

    task automatic test_reset_mid();
        clr();
        send(hdr(4'd9, 8'd4));
        send(32'h11);
        send(32'h22);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (mpu.O_Busy !== 1'b0 || length !== 8'd0 ||
            mpu.O_Drop_Cnt !== 8'd0 || mpu.O_CommitNo !== 4'd0) begin
            errors++;
            $display("FAIL rst_mid_state: busy=%0b len=%0d drop=%0d no=%0d",
                     mpu.O_Busy, length, mpu.O_Drop_Cnt, mpu.O_CommitNo);
        end
        clr();
        done = 1'b1;
        tick();
        tick();
        done = 1'b0;
        tick();
        checks++;
        if (commit_cnt != 0 || start_cnt != 0) begin
            errors++;
            $display("FAIL rst_mid_done: commits=%0d starts=%0d want 0/0",
                     commit_cnt, start_cnt);
        end
        send(hdr(4'd10, 8'd1));
        send(32'h33);
        tick();
        tick();
        checks++;
        if (wa.size() != 1 || start_cnt != 1) begin
            errors++;
            $display("FAIL rst_mid_next: wr=%0d st=%0d want 1/1",
                     wa.size(), start_cnt);
        end else begin
            checks++;
            if (wa[0] !== 8'd0 || wd[0] !== 32'h33) begin
                errors++;
                $display("FAIL rst_mid_wr: a=%0d d=%0h want 0/33",
                         wa[0], wd[0]);
            end
        end
        finish_thread("rst_mid", 4'd10);
    endtask

    task automatic test_len_zero();
        clr();
        send(hdr(4'd11, 8'd0));
`ifdef TPU_RCV_LEN_CHECK_EN
        checks++;
        if (err !== 1'b1 || mpu.O_Req_Commit !== 1'b0) begin
            errors++;
            $display("FAIL len0_err: err=%0b commit=%0b want 1/0",
                     err, mpu.O_Req_Commit);
        end
`else
        checks++;
        if (mpu.O_Req_Commit !== 1'b1 || mpu.O_CommitNo !== 4'd11) begin
            errors++;
            $display("FAIL len0_commit: req=%0b no=%0d want 1/11",
                     mpu.O_Req_Commit, mpu.O_CommitNo);
        end
`endif
        tick();
        tick();
        tick();
        checks++;
`ifdef TPU_RCV_LEN_CHECK_EN
        if (commit_cnt != 0 || err_cnt != 1 || start_cnt != 0 ||
            wa.size() != 0 || mpu.O_Busy !== 1'b0) begin
`else
        if (commit_cnt != 1 || err_cnt != 0 || start_cnt != 0 ||
            wa.size() != 0 || mpu.O_Busy !== 1'b0) begin
`endif
            errors++;
            $display("FAIL len0_counts: c=%0d e=%0d s=%0d w=%0d b=%0b",
                     commit_cnt, err_cnt, start_cnt, wa.size(),
                     mpu.O_Busy);
        end
    endtask

    task automatic test_back_to_back();
        clr();
        send(hdr(4'd12, 8'd1));
        send(32'h44);
        tick();
        tick();
        finish_thread("b2b_first", 4'd12);
        send(hdr(4'd15, 8'd1));
        send(32'h55);
        tick();
        tick();
        checks++;
        if (wa.size() != 2 || start_cnt != 2 ||
            mpu.O_Drop_Cnt !== 8'd0) begin
            errors++;
            $display("FAIL b2b_counts: wr=%0d st=%0d drop=%0d want 2/2/0",
                     wa.size(), start_cnt, mpu.O_Drop_Cnt);
        end
        finish_thread("b2b_second", 4'd15);
        checks++;
        if (commit_cnt != 2) begin
            errors++;
            $display("FAIL b2b_commits: got %0d want 2", commit_cnt);
        end
    endtask

    initial begin
        mpu.I_Req_Instr = 1'b0;
        mpu.I_Instr     = '0;
        test_reset();
        test_basic();
        test_gaps();
        test_drop();
        test_reset_mid();
        test_len_zero();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/tpu_thread_rcv.md
TPU_THREAD_RCV -- requirements
Module: tpu_thread_rcv

Interface
REQ-001 Parameter WIDTH_INSTR, 32, instruction word width; SHALL equal the width of instr_t.
REQ-002 Parameter WIDTH_ENTRY_STH, 4, commit/issue number width; SHALL match the commit number width on the MPU side.
REQ-003 Parameter WIDTH_LEN, 8, thread length field width.
REQ-004 Parameter IMEM_DEPTH, 256, local instruction memory depth in words; SHALL be a power of two and SHALL NOT exceed 2^WIDTH_LEN.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 Ports: clock  in  1  sole clock.
REQ-007 Ports: reset  in  1  synchronous active-high reset.
REQ-008 Ports: I_Req_Instr  in  1  instruction word valid from MPU dispatch.
REQ-009 Ports: I_Instr  in  WIDTH_INSTR  header or instruction word.
REQ-010 Ports: O_Busy  out  1  tells the MPU that words are not accepted.
REQ-011 Ports: O_IMem_We, O_IMem_Addr, O_IMem_Data  out  1, log2(IMEM_DEPTH), WIDTH_INSTR  local instruction memory write port.
REQ-012 Ports: O_Start, O_Length  out  1, WIDTH_LEN  start pulse to TPU core and program length.
REQ-013 Ports: I_Done  in  1  TPU core finished the thread.
REQ-014 Ports: O_Req_Commit, O_CommitNo  out  1, WIDTH_ENTRY_STH  commit pulse and number to MPU.
REQ-015 Ports: O_Drop_Cnt  out  8  count of dropped words; O_Err  out  1  length error pulse (present only with the Configuration macro).

Function
REQ-016 FSM SHALL have states IDLE, LOAD, RUN, COMMIT.
REQ-017 Header format: I_Instr[WIDTH_ENTRY_STH-1:0] = issue number; I_Instr[WIDTH_ENTRY_STH+WIDTH_LEN-1:WIDTH_ENTRY_STH] = length L.
REQ-018 IDLE: a word with I_Req_Instr=1 SHALL be taken as the header; issue number and L SHALL be latched; the write address SHALL be cleared; the next state SHALL be LOAD.
REQ-019 LOAD: each valid word SHALL be written one cycle later: O_IMem_We=1, O_IMem_Addr = word index, O_IMem_Data = word.
REQ-020 LOAD: the address SHALL increment by one per accepted word; cycles without valid SHALL stall and SHALL NOT advance the address.
REQ-021 On acceptance of word L: the state SHALL become RUN; O_Start SHALL pulse for one cycle in the cycle after the last O_IMem_We; O_Length SHALL equal L and SHALL be held until the next header.
REQ-022 O_Busy SHALL be 1 in RUN and COMMIT, and 0 in IDLE and LOAD.
REQ-023 Valid words in RUN or COMMIT SHALL be dropped; O_Drop_Cnt SHALL increment and saturate at 255.
REQ-024 RUN: on I_Done=1 the next state SHALL be COMMIT; I_Done in any other state SHALL be ignored.
REQ-025 COMMIT: O_Req_Commit SHALL be 1 for exactly one cycle with O_CommitNo = latched issue number; the next state SHALL be IDLE.
REQ-026 A header arriving in the cycle after COMMIT (IDLE) SHALL be accepted with no gap.
REQ-027 L=0 without the macro: no writes and no O_Start; the FSM SHALL go directly to COMMIT (empty-thread commit).
REQ-028 L greater than IMEM_DEPTH without the macro: the address SHALL wrap modulo IMEM_DEPTH.
REQ-029 A header latch SHALL load all WIDTH_ENTRY_STH bits of the issue number without truncation.

Reset
REQ-030 Reset SHALL force IDLE, and SHALL drive O_Busy, O_IMem_We, O_Start, O_Req_Commit, and O_Err to 0.
REQ-031 Reset SHALL clear O_IMem_Addr, O_IMem_Data, O_Length, O_CommitNo, O_Drop_Cnt, and the latched header.
REQ-032 Reset mid-LOAD or mid-RUN SHALL abandon the thread with no commit; I_Done arriving after reset SHALL be ignored.

Configuration
REQ-033 Macro TPU_RCV_LEN_CHECK_EN: when defined, a header with L=0 or L greater than IMEM_DEPTH SHALL be rejected, O_Err SHALL pulse one cycle, and the FSM SHALL stay in IDLE with no commit.
REQ-034 When TPU_RCV_LEN_CHECK_EN is undefined, REQ-027 and REQ-028 SHALL apply, and O_Err SHALL be absent.

Structure
REQ-035 The header field offsets and the state enum SHALL live in pkg_tpu.
REQ-036 The commit number type SHALL be shared through pkg_mpu.
REQ-037 The block SHALL be a single module with no sub-module.

Verification
REQ-038 Header issue=5, L=3, then 3 words back-to-back -> 3 writes at addresses 0..2; O_Start one cycle after the third write with O_Length=3; I_Done -> O_Req_Commit one cycle with O_CommitNo=5.
REQ-039 Header L=4 with valid gaps of 2 cycles -> addresses 0..3 contiguous; no extra writes.
REQ-040 Words sent during RUN (×3) -> no writes; O_Drop_Cnt=3; O_Busy=1.
REQ-041 Reset asserted after 2 of 4 words -> IDLE; later I_Done -> no commit; next header accepted.
REQ-042 Header L=0: with the macro -> O_Err pulse and no commit; without the macro -> commit in the next cycle with no O_Start.
REQ-043 Commit followed by a new header in the next cycle -> accepted; the second commit carries the new issue number.
